// File: rtl/sampling_rate_ctrl_if.sv
// Button/hold controls and sample-strobe status of the sampling-rate controller.
// The master drives controls and the slave (the controller) drives status.
interface sampling_rate_ctrl_if #(
  parameter int unsigned NUM_MODES = 4
);
  localparam int unsigned MODE_W = $clog2(NUM_MODES);

  logic              iBtnUp;
  logic              iBtnDn;
  logic              iHold;
  logic              oSmpEn;
  logic              oReady;
  logic              oBusy;
  logic [MODE_W-1:0] oMode;
  logic              oModeChg;

  modport master (
    output iBtnUp, iBtnDn, iHold,
    input  oSmpEn, oReady, oBusy, oMode, oModeChg
  );

  modport slave (
    input  iBtnUp, iBtnDn, iHold,
    output oSmpEn, oReady, oBusy, oMode, oModeChg
  );
endinterface

// File: rtl/sampling_rate_ctrl.sv
// Sample-rate controller: power-up delay, per-mode clock divider strobe and
// debounced up/down mode selection applied on strobe boundaries.
module sampling_rate_ctrl #(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DIV_BASE     = 1,
  parameter int unsigned DIV_MULT     = 10,
  parameter int unsigned DEBOUNCE_CYC = 5_000_000,
  parameter int unsigned READY_DLY    = 80,
  parameter bit          WRAP         = 1'b1
) (
  input logic                 Fg_CLK,
  input logic                 Fg_RESETn,
  sampling_rate_ctrl_if.slave bus
);

  localparam int unsigned MODE_W = $clog2(NUM_MODES);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned DLY_W  = (READY_DLY > 1) ? $clog2(READY_DLY) : 1;

  localparam logic [DEB_W-1:0]  DebMax   = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DLY_W-1:0]  DlyLast  = DLY_W'(READY_DLY - 1);
  localparam logic [MODE_W-1:0] ModeLast = MODE_W'(NUM_MODES - 1);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [NUM_MODES*CNT_W-1:0] build_divs();
    logic [NUM_MODES*CNT_W-1:0] tab;
    logic [63:0]                d;
    tab = '0;
    d   = 64'(DIV_BASE);
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      tab[m*CNT_W +: CNT_W] = CNT_W'(d);
      d = d * 64'(DIV_MULT);
    end
    return tab;
  endfunction

  localparam logic [NUM_MODES*CNT_W-1:0] DivTab = build_divs();

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  cnt_t              div_q, div_d, div_last;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [MODE_W-1:0] mode_q, mode_d, tgt_q, tgt_d, tgt_new;
  logic              pend_q, pend_d;
  logic              up_prev_q, dn_prev_q;
  logic              smp_q, smp_d, rdy_q, chg_q, chg_d;
  logic              busy, run, enter_run;
  logic              edge_up, edge_dn, deb_sat, accept, div_wrap, apply;

  // State register
  always_ff @(posedge Fg_CLK) begin
    if (!Fg_RESETn) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (dly_q == DlyLast) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == StInit);
    run       = (state_q == StRun);
    enter_run = busy && (dly_q == DlyLast);
  end

  always_comb begin
    edge_up  = bus.iBtnUp & ~up_prev_q;
    edge_dn  = bus.iBtnDn & ~dn_prev_q;
    deb_sat  = (deb_q == DebMax);
    // Simultaneous edges cancel and leave the debounce window untouched
    accept   = run & (edge_up ^ edge_dn) & deb_sat & ~pend_q;
    div_last = DivTab[32'(mode_q) * CNT_W +: CNT_W] - cnt_t'(1);
    div_wrap = (div_q == div_last);
    apply    = run & pend_q & (bus.iHold | div_wrap);

    tgt_new = mode_q;
    if (edge_up) begin
      if (mode_q == ModeLast) tgt_new = WRAP ? '0 : mode_q;
      else                    tgt_new = mode_q + MODE_W'(1);
    end else begin
      if (mode_q == '0) tgt_new = WRAP ? ModeLast : mode_q;
      else              tgt_new = mode_q - MODE_W'(1);
    end

    dly_d = (busy && !enter_run) ? dly_q + DLY_W'(1) : dly_q;
    deb_d = accept ? '0 : (deb_sat ? deb_q : deb_q + DEB_W'(1));

    if (!run || apply || (div_wrap && !bus.iHold)) begin
      div_d = '0;
    end else if (bus.iHold) begin
      div_d = div_q;
    end else begin
      div_d = div_q + cnt_t'(1);
    end

    smp_d  = run & ~bus.iHold & div_wrap;
    mode_d = apply ? tgt_q : mode_q;
    chg_d  = apply;

    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (accept && (tgt_new != mode_q)) begin
      pend_d = 1'b1;
      tgt_d  = tgt_new;
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (!Fg_RESETn) begin
      dly_q     <= '0;
      div_q     <= '0;
      deb_q     <= '0;
      mode_q    <= '0;
      tgt_q     <= '0;
      pend_q    <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      smp_q     <= 1'b0;
      rdy_q     <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      mode_q    <= mode_d;
      tgt_q     <= tgt_d;
      pend_q    <= pend_d;
      up_prev_q <= bus.iBtnUp;
      dn_prev_q <= bus.iBtnDn;
      smp_q     <= smp_d;
      rdy_q     <= enter_run;
      chg_q     <= chg_d;
    end
  end

  assign bus.oSmpEn   = smp_q;
  assign bus.oReady   = rdy_q;
  assign bus.oBusy    = busy;
  assign bus.oMode    = mode_q;
  assign bus.oModeChg = chg_q;

endmodule

// File: tb/tb_sampling_rate_ctrl.sv
// Bench: wrapping (A) and saturating (B) controllers share stimulus and are checked
// every cycle against a countdown/age based model, plus directed literal checks.
module tb_sampling_rate_ctrl;

  localparam int NM  = 4;
  localparam int DEB = 8;
  localparam int RDY = 4;

  logic clk = 1'b0;
  logic rst_n, up, dn, hold;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sampling_rate_ctrl_if #(.NUM_MODES(NM)) ifa ();
  sampling_rate_ctrl_if #(.NUM_MODES(NM)) ifb ();

  assign ifa.iBtnUp = up;
  assign ifa.iBtnDn = dn;
  assign ifa.iHold  = hold;
  assign ifb.iBtnUp = up;
  assign ifb.iBtnDn = dn;
  assign ifb.iHold  = hold;

  sampling_rate_ctrl #(
    .NUM_MODES(NM), .CNT_W(16), .DIV_BASE(1), .DIV_MULT(3),
    .DEBOUNCE_CYC(DEB), .READY_DLY(RDY), .WRAP(1'b1)
  ) dut_a (
    .Fg_CLK   (clk),
    .Fg_RESETn(rst_n),
    .bus      (ifa.slave)
  );

  sampling_rate_ctrl #(
    .NUM_MODES(NM), .CNT_W(16), .DIV_BASE(1), .DIV_MULT(3),
    .DEBOUNCE_CYC(DEB), .READY_DLY(RDY), .WRAP(1'b0)
  ) dut_b (
    .Fg_CLK   (clk),
    .Fg_RESETn(rst_n),
    .bus      (ifb.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int m);
    int d = 1;
    for (int k = 0; k < m; k++) d = d * 3;
    return d;
  endfunction

  // Model: index 0 wraps at the ends, index 1 saturates
  int age[2], left[2], mode[2], tgt[2], since[2];
  bit pend[2], e_smp[2], e_rdy[2], e_chg[2], e_busy[2];
  bit prev_up, prev_dn, model_ok = 1'b0;

  always @(posedge clk) begin
    bit eu, ed, acc, wrap;
    int t;
    eu = up && !prev_up;
    ed = dn && !prev_dn;
    for (int i = 0; i < 2; i++) begin
      wrap = (i == 0);
      if (!rst_n) begin
        age[i] = 0; left[i] = 0; mode[i] = 0; tgt[i] = 0; since[i] = 0; pend[i] = 0;
        e_smp[i] = 0; e_rdy[i] = 0; e_chg[i] = 0; e_busy[i] = 1;
      end else begin
        e_smp[i] = 0; e_rdy[i] = 0; e_chg[i] = 0;
        if (e_busy[i]) begin
          if (age[i] == RDY - 1) begin
            e_busy[i] = 0; e_rdy[i] = 1; left[i] = div_of(mode[i]);
          end else begin
            age[i]++;
          end
          if (since[i] < 1000) since[i]++;
        end else begin
          acc = (eu != ed) && (since[i] >= DEB - 1) && !pend[i];
          if (!hold) begin
            if (left[i] == 1) begin
              e_smp[i] = 1;
              if (pend[i]) begin mode[i] = tgt[i]; pend[i] = 0; e_chg[i] = 1; end
              left[i] = div_of(mode[i]);
            end else begin
              left[i]--;
            end
          end else if (pend[i]) begin
            mode[i] = tgt[i]; pend[i] = 0; e_chg[i] = 1; left[i] = div_of(mode[i]);
          end
          if (acc) since[i] = 0;
          else if (since[i] < 1000) since[i]++;
          if (acc) begin
            if (eu) t = (mode[i] == NM - 1) ? (wrap ? 0 : mode[i]) : mode[i] + 1;
            else    t = (mode[i] == 0) ? (wrap ? NM - 1 : 0) : mode[i] - 1;
            if (t != mode[i]) begin tgt[i] = t; pend[i] = 1; end
          end
        end
      end
    end
    prev_up = rst_n ? up : 1'b0;
    prev_dn = rst_n ? dn : 1'b0;
    if (!rst_n) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("A smp",   int'(ifa.oSmpEn),   int'(e_smp[0]));
      check("A ready", int'(ifa.oReady),   int'(e_rdy[0]));
      check("A busy",  int'(ifa.oBusy),    int'(e_busy[0]));
      check("A mode",  int'(ifa.oMode),    mode[0]);
      check("A chg",   int'(ifa.oModeChg), int'(e_chg[0]));
      check("B smp",   int'(ifb.oSmpEn),   int'(e_smp[1]));
      check("B ready", int'(ifb.oReady),   int'(e_rdy[1]));
      check("B busy",  int'(ifb.oBusy),    int'(e_busy[1]));
      check("B mode",  int'(ifb.oMode),    mode[1]);
      check("B chg",   int'(ifb.oModeChg), int'(e_chg[1]));
    end
  end

  int c_smp[2], c_chg[2], c_busy[2], c_rdy[2];

  task automatic clr();
    for (int i = 0; i < 2; i++) begin c_smp[i] = 0; c_chg[i] = 0; c_busy[i] = 0; c_rdy[i] = 0; end
  endtask

  task automatic sample();
    c_smp[0] += int'(ifa.oSmpEn);  c_chg[0] += int'(ifa.oModeChg);
    c_busy[0] += int'(ifa.oBusy);  c_rdy[0] += int'(ifa.oReady);
    c_smp[1] += int'(ifb.oSmpEn);  c_chg[1] += int'(ifb.oModeChg);
    c_busy[1] += int'(ifb.oBusy);  c_rdy[1] += int'(ifb.oReady);
  endtask

  task automatic count_cycles(input int n);
    clr();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic press(input bit u, input bit d);
    @(negedge clk); up = u; dn = d;
    @(negedge clk); up = 1'b0; dn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; up = 1'b0; dn = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    // T1: power-up delay
    clr();
    sample();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin @(negedge clk); sample(); end
    check("T1 busy cycles", c_busy[0], 4);
    check("T1 ready pulses", c_rdy[0], 1);
    count_cycles(5);
    check("T1 smp every cycle", c_smp[0], 5);

    // T2: single up press
    press(1, 0);
    count_cycles(12);
    check("T2 mode", int'(ifa.oMode), 1);
    check("T2 chg pulses", c_chg[0], 1);
    count_cycles(30);
    check("T2 smp period 3", c_smp[0], 10);

    // T3: second edge inside debounce window is dropped
    press(1, 0);
    @(negedge clk);
    press(1, 0);
    count_cycles(40);
    check("T3 mode", int'(ifa.oMode), 2);
    count_cycles(90);
    check("T3 smp period 9", c_smp[0], 10);

    // T4: down from mode 0 wraps (A) or saturates (B)
    press(0, 1); count_cycles(40);
    press(0, 1); count_cycles(40);
    check("T4 A mode 0", int'(ifa.oMode), 0);
    check("T4 B mode 0", int'(ifb.oMode), 0);
    press(0, 1);
    count_cycles(40);
    check("T4 A wrap mode", int'(ifa.oMode), 3);
    check("T4 A chg", c_chg[0], 1);
    check("T4 B mode held", int'(ifb.oMode), 0);
    check("T4 B no chg", c_chg[1], 0);
    count_cycles(81);
    check("T4 smp period 27", c_smp[0], 3);

    // T5: simultaneous edges ignored, next press accepted
    press(1, 1);
    press(1, 0);
    count_cycles(40);
    check("T5 A mode", int'(ifa.oMode), 0);
    check("T5 B mode", int'(ifb.oMode), 1);

    // T6: pending change applied under hold
    press(1, 0); count_cycles(40);
    press(1, 0); count_cycles(40);
    check("T6 A mode 2", int'(ifa.oMode), 2);
    @(negedge clk); up = 1'b1;
    @(negedge clk); up = 1'b0; hold = 1'b1;
    count_cycles(20);
    check("T6 no smp in hold", c_smp[0], 0);
    check("T6 A mode 3", int'(ifa.oMode), 3);
    check("T6 A chg", c_chg[0], 1);
    check("T6 B no chg", c_chg[1], 0);
    hold = 1'b0;
    count_cycles(30);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("T6 rst smp", int'(ifa.oSmpEn), 0);
    check("T6 rst ready", int'(ifa.oReady), 0);
    check("T6 rst busy", int'(ifa.oBusy), 1);
    check("T6 rst mode", int'(ifa.oMode), 0);
    check("T6 rst chg", int'(ifa.oModeChg), 0);
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      up    = ($urandom % 6) == 0;
      dn    = ($urandom % 7) == 0;
      if (($urandom % 16) == 0) hold = ~hold;
      rst_n = ($urandom % 600) != 0;
    end
    @(negedge clk); up = 1'b0; dn = 1'b0; hold = 1'b0; rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
